// File: rtl/mem_port_arbiter_if.sv
// One memory request port: request payload towards a memory, grant and in-order response back.
// A request transfers in the cycle where req and gnt are both high.
// The master holds req and payload until gnt.
// r_valid is a one-cycle pulse with no back-pressure, one per transfer, in order.
interface mem_port_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic                  req;
  logic [ADDR_WIDTH-1:0] add;
  logic                  wen;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] be;
  logic                  gnt;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_rdata;

  modport master (output req, add, wen, wdata, be, input gnt, r_valid, r_rdata);
  modport slave  (input req, add, wen, wdata, be, output gnt, r_valid, r_rdata);
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single memory port.
// Responses are routed back in order through an owner FIFO. The number of outstanding transfers is capped.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_port_if.slave            m0,
  mem_port_if.slave            m1,
  mem_port_if.master           data,
  output logic [CNT_WIDTH-1:0] outstanding_o,
  output logic                 err_o,
  output logic                 prio_o
);

  localparam int PTR_WIDTH = $clog2(MAX_OUTSTANDING);
  localparam logic [0:0] ID_M0 = 1'b0;
  localparam logic [0:0] ID_M1 = 1'b1;
  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OUTSTANDING);

  logic [0:0]                 prio_q;
  logic [0:0]                 sel;
  logic [MAX_OUTSTANDING-1:0] owner_q;
  logic [PTR_WIDTH-1:0]       wr_ptr_q;
  logic [PTR_WIDTH-1:0]       rd_ptr_q;
  logic [CNT_WIDTH-1:0]       cnt_q;
  logic                       err_q;
  logic                       full;
  logic                       empty;
  logic                       push;
  logic                       pop;
  logic                       head;

  logic [ADDR_WIDTH-1:0]      sel_add;
  logic                       sel_wen;
  logic [DATA_WIDTH-1:0]      sel_wdata;
  logic [STRB_WIDTH-1:0]      sel_be;

  assign full  = (cnt_q == MAX_CNT);
  assign empty = (cnt_q == '0);

  always_comb begin
    sel = ID_M0;
    if (m0.req && m1.req) sel = prio_q;
    else if (m1.req)      sel = ID_M1;
  end

  // full is registered, so a response popping this cycle cannot reopen the port combinationally
  assign data.req = (m0.req | m1.req) & ~full;
  assign push     = data.req & data.gnt;
  assign pop      = data.r_valid & ~empty;
  assign head     = owner_q[rd_ptr_q];

  always_comb begin
    sel_add   = '0;
    sel_wen   = 1'b0;
    sel_wdata = '0;
    sel_be    = '0;
    if (data.req) begin
      if (sel == ID_M1) begin
        sel_add   = m1.add;
        sel_wen   = m1.wen;
        sel_wdata = m1.wdata;
        sel_be    = m1.be;
      end else begin
        sel_add   = m0.add;
        sel_wen   = m0.wen;
        sel_wdata = m0.wdata;
        sel_be    = m0.be;
      end
    end
  end

  assign data.add   = sel_add;
  assign data.wen   = sel_wen;
  assign data.wdata = sel_wdata;
  assign data.be    = sel_be;

  assign m0.gnt     = push & (sel == ID_M0);
  assign m1.gnt     = push & (sel == ID_M1);
  assign m0.r_valid = pop & (head == ID_M0);
  assign m1.r_valid = pop & (head == ID_M1);
  assign m0.r_rdata = data.r_rdata;
  assign m1.r_rdata = data.r_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q   <= ID_M0;
      owner_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push) begin
        owner_q[wr_ptr_q] <= sel;
        wr_ptr_q          <= wr_ptr_q + PTR_WIDTH'(1);
        prio_q            <= ~sel;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_WIDTH'(1);
      cnt_q <= cnt_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
      // a response with nothing outstanding means memory and arbiter lost sync
      if (data.r_valid && empty) err_q <= 1'b1;
    end
  end

  assign outstanding_o = cnt_q;
  assign err_o         = err_q;
  assign prio_o        = prio_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// Inputs change on the falling edge, and outputs are sampled 1 time unit later.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int MO = 4;
  localparam int CW = $clog2(MO) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CW-1:0] outstanding;
  logic          err;
  logic          prio;
  int            checks = 0;
  int            errors = 0;
  logic [0:0]    exp_q[$];

  mem_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) m0_if ();
  mem_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) m1_if ();
  mem_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) mem_if ();

  mem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .MAX_OUTSTANDING(MO), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .m0(m0_if), .m1(m1_if), .data(mem_if),
    .outstanding_o(outstanding), .err_o(err), .prio_o(prio)
  );

  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic idle_all();
    m0_if.req = 0; m0_if.add = '0; m0_if.wen = 0; m0_if.wdata = '0; m0_if.be = '0;
    m1_if.req = 0; m1_if.add = '0; m1_if.wen = 0; m1_if.wdata = '0; m1_if.be = '0;
    mem_if.gnt = 0; mem_if.r_valid = 0; mem_if.r_rdata = '0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(); reset = 1'b1; idle_all();
    step(); step(); reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset(); #1;
    checks++; if (outstanding !== 0) begin errors++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", err); end
    checks++; if (prio !== 1'b0) begin errors++; $display("FAIL reset_prio: got %0b expected 0", prio); end
    checks++; if (mem_if.req !== 1'b0 || mem_if.add !== '0 || mem_if.wen !== 1'b0 || mem_if.wdata !== '0 || mem_if.be !== '0)
      begin errors++; $display("FAIL reset_mem_out: got req=%0b add=%h wen=%0b wdata=%h be=%h expected all 0", mem_if.req, mem_if.add, mem_if.wen, mem_if.wdata, mem_if.be); end
    checks++; if (m0_if.gnt !== 1'b0 || m1_if.gnt !== 1'b0 || m0_if.r_valid !== 1'b0 || m1_if.r_valid !== 1'b0)
      begin errors++; $display("FAIL reset_port_out: got gnt=%0b%0b r_valid=%0b%0b expected 0", m0_if.gnt, m1_if.gnt, m0_if.r_valid, m1_if.r_valid); end
  endtask

  task automatic test_single_read();
    step(); m0_if.req = 1; m0_if.add = 32'h10; m0_if.wen = 0; m0_if.be = 4'hF; mem_if.gnt = 1; #1;
    checks++; if (m0_if.gnt !== 1'b1 || m1_if.gnt !== 1'b0) begin errors++; $display("FAIL single_gnt: got m0=%0b m1=%0b expected 1 0", m0_if.gnt, m1_if.gnt); end
    checks++; if (mem_if.req !== 1'b1 || mem_if.add !== 32'h10 || mem_if.wen !== 1'b0) begin errors++; $display("FAIL single_mem_req: got req=%0b add=%h wen=%0b expected 1 10 0", mem_if.req, mem_if.add, mem_if.wen); end
    step(); idle_all(); #1;
    checks++; if (outstanding !== 1) begin errors++; $display("FAIL single_outstanding1: got %0d expected 1", outstanding); end
    step(); mem_if.r_valid = 1; mem_if.r_rdata = 32'hDEADBEEF; #1;
    checks++; if (m0_if.r_valid !== 1'b1 || m0_if.r_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_resp: got v=%0b d=%h expected 1 deadbeef", m0_if.r_valid, m0_if.r_rdata); end
    checks++; if (m1_if.r_valid !== 1'b0) begin errors++; $display("FAIL single_m1_quiet: got %0b expected 0", m1_if.r_valid); end
    step(); idle_all(); #1;
    checks++; if (outstanding !== 0) begin errors++; $display("FAIL single_outstanding0: got %0d expected 0", outstanding); end
    checks++; if (prio !== 1'b1) begin errors++; $display("FAIL single_prio: got %0b expected 1", prio); end
  endtask

  task automatic test_back_to_back();
    logic [0:0]  id;
    logic [31:0] exp_add;
    int          exp_cnt;
    do_reset();
    exp_q.delete();
    for (int k = 0; k < 10; k++) begin
      step();
      m0_if.req = (k < 8); m0_if.add = 32'h100 + k;
      m1_if.req = (k < 8); m1_if.add = 32'h200 + k;
      mem_if.gnt = 1;
      mem_if.r_valid = (k >= 2); mem_if.r_rdata = 32'(k);
      #1;
      exp_cnt = ((k < 8) ? k : 8) - ((k > 2) ? k - 2 : 0);
      checks++; if (outstanding !== CW'(exp_cnt)) begin errors++; $display("FAIL b2b_outstanding k=%0d: got %0d expected %0d", k, outstanding, exp_cnt); end
      if (k < 8) begin
        id = 1'(k % 2);
        exp_add = (id == 1'b0) ? 32'h100 + k : 32'h200 + k;
        checks++; if (m0_if.gnt !== ~id || m1_if.gnt !== id) begin errors++; $display("FAIL b2b_gnt k=%0d: got m0=%0b m1=%0b expected m%0d", k, m0_if.gnt, m1_if.gnt, id); end
        checks++; if (mem_if.add !== exp_add) begin errors++; $display("FAIL b2b_add k=%0d: got %h expected %h", k, mem_if.add, exp_add); end
        exp_q.push_back(id);
      end
      if (k >= 2) begin
        id = exp_q.pop_front();
        checks++; if (m0_if.r_valid !== ~id || m1_if.r_valid !== id) begin errors++; $display("FAIL b2b_route k=%0d: got m0=%0b m1=%0b expected m%0d", k, m0_if.r_valid, m1_if.r_valid, id); end
      end
    end
    step(); idle_all(); #1;
    checks++; if (outstanding !== 0) begin errors++; $display("FAIL b2b_drain: got %0d expected 0", outstanding); end
    checks++; if (prio !== 1'b0) begin errors++; $display("FAIL b2b_prio: got %0b expected 0", prio); end
  endtask

  task automatic test_gnt_stall();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(); m0_if.req = 1; m0_if.add = 32'hA0; m1_if.req = 1; m1_if.add = 32'hB0; mem_if.gnt = 0; #1;
      checks++; if (m0_if.gnt !== 1'b0 || m1_if.gnt !== 1'b0) begin errors++; $display("FAIL stall_gnt k=%0d: got %0b%0b expected 00", k, m0_if.gnt, m1_if.gnt); end
      checks++; if (mem_if.req !== 1'b1 || mem_if.add !== 32'hA0) begin errors++; $display("FAIL stall_add k=%0d: got req=%0b add=%h expected 1 a0", k, mem_if.req, mem_if.add); end
      checks++; if (prio !== 1'b0) begin errors++; $display("FAIL stall_prio k=%0d: got %0b expected 0", k, prio); end
    end
    step(); mem_if.gnt = 1; #1;
    checks++; if (m0_if.gnt !== 1'b1 || m1_if.gnt !== 1'b0) begin errors++; $display("FAIL stall_release: got m0=%0b m1=%0b expected 1 0", m0_if.gnt, m1_if.gnt); end
    step(); idle_all(); #1;
    checks++; if (prio !== 1'b1 || outstanding !== 1) begin errors++; $display("FAIL stall_after: got prio=%0b cnt=%0d expected 1 1", prio, outstanding); end
    step(); mem_if.r_valid = 1; #1;
    checks++; if (m0_if.r_valid !== 1'b1 || m1_if.r_valid !== 1'b0) begin errors++; $display("FAIL stall_resp: got %0b%0b expected m0", m0_if.r_valid, m1_if.r_valid); end
    step(); idle_all();
  endtask

  task automatic test_full();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(); m0_if.req = 1; m0_if.add = 32'h40 + k; mem_if.gnt = 1; #1;
      checks++; if (m0_if.gnt !== 1'b1) begin errors++; $display("FAIL full_fill k=%0d: got %0b expected 1", k, m0_if.gnt); end
    end
    step(); #1;
    checks++; if (mem_if.req !== 1'b0 || m0_if.gnt !== 1'b0) begin errors++; $display("FAIL full_block: got req=%0b gnt=%0b expected 0 0", mem_if.req, m0_if.gnt); end
    checks++; if (outstanding !== CW'(4)) begin errors++; $display("FAIL full_count: got %0d expected 4", outstanding); end
    step(); mem_if.r_valid = 1; #1;
    checks++; if (mem_if.req !== 1'b0 || m0_if.r_valid !== 1'b1) begin errors++; $display("FAIL full_pop_same_cycle: got req=%0b rv=%0b expected 0 1", mem_if.req, m0_if.r_valid); end
    step(); mem_if.r_valid = 0; #1;
    checks++; if (outstanding !== 3 || mem_if.req !== 1'b1 || m0_if.gnt !== 1'b1) begin errors++; $display("FAIL full_reopen: got cnt=%0d req=%0b gnt=%0b expected 3 1 1", outstanding, mem_if.req, m0_if.gnt); end
    step(); m0_if.req = 0; mem_if.gnt = 0; #1;
    checks++; if (outstanding !== CW'(4)) begin errors++; $display("FAIL full_refill: got %0d expected 4", outstanding); end
    for (int k = 0; k < 4; k++) begin step(); mem_if.r_valid = 1; end
    step(); idle_all(); #1;
    checks++; if (outstanding !== 0 || err !== 1'b0) begin errors++; $display("FAIL full_drain: got cnt=%0d err=%0b expected 0 0", outstanding, err); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    step(); m0_if.req = 1; m0_if.add = 32'h300; mem_if.gnt = 1;
    step(); m0_if.req = 0; m1_if.req = 1; m1_if.add = 32'h304; m1_if.wen = 1; m1_if.wdata = 32'hCAFEF00D; m1_if.be = 4'hC; #1;
    checks++; if (m1_if.gnt !== 1'b1 || mem_if.wen !== 1'b1 || mem_if.wdata !== 32'hCAFEF00D || mem_if.be !== 4'hC || mem_if.add !== 32'h304)
      begin errors++; $display("FAIL simul_write: got gnt=%0b wen=%0b wdata=%h be=%h add=%h expected 1 1 cafef00d c 304", m1_if.gnt, mem_if.wen, mem_if.wdata, mem_if.be, mem_if.add); end
    step(); m1_if.req = 0; m1_if.wen = 0; m0_if.req = 1; m0_if.add = 32'h308; mem_if.r_valid = 1; mem_if.r_rdata = 32'h11; #1;
    checks++; if (outstanding !== 2) begin errors++; $display("FAIL simul_pre_count: got %0d expected 2", outstanding); end
    checks++; if (m0_if.gnt !== 1'b1 || m0_if.r_valid !== 1'b1 || m1_if.r_valid !== 1'b0) begin errors++; $display("FAIL simul_push_pop: got gnt=%0b rv=%0b%0b expected 1 m0", m0_if.gnt, m0_if.r_valid, m1_if.r_valid); end
    step(); m0_if.req = 0; mem_if.gnt = 0; mem_if.r_rdata = 32'h22; #1;
    checks++; if (outstanding !== 2) begin errors++; $display("FAIL simul_post_count: got %0d expected 2", outstanding); end
    checks++; if (m1_if.r_valid !== 1'b1 || m0_if.r_valid !== 1'b0 || m1_if.r_rdata !== 32'h22) begin errors++; $display("FAIL simul_head: got rv=%0b%0b d=%h expected m1 22", m0_if.r_valid, m1_if.r_valid, m1_if.r_rdata); end
    step(); mem_if.r_rdata = 32'h33; #1;
    checks++; if (m0_if.r_valid !== 1'b1 || m1_if.r_valid !== 1'b0) begin errors++; $display("FAIL simul_tail: got rv=%0b%0b expected m0", m0_if.r_valid, m1_if.r_valid); end
    step(); idle_all(); #1;
    checks++; if (outstanding !== 0) begin errors++; $display("FAIL simul_drain: got %0d expected 0", outstanding); end
  endtask

  task automatic test_error();
    do_reset();
    step(); m0_if.req = 1; mem_if.gnt = 1;
    step(); idle_all(); mem_if.r_valid = 1;
    step(); idle_all(); #1;
    checks++; if (prio !== 1'b1 || outstanding !== 0 || err !== 1'b0) begin errors++; $display("FAIL err_setup: got prio=%0b cnt=%0d err=%0b expected 1 0 0", prio, outstanding, err); end
    step(); mem_if.r_valid = 1; mem_if.r_rdata = 32'h55; #1;
    checks++; if (m0_if.r_valid !== 1'b0 || m1_if.r_valid !== 1'b0) begin errors++; $display("FAIL err_no_route: got %0b%0b expected 00", m0_if.r_valid, m1_if.r_valid); end
    step(); mem_if.r_valid = 0; #1;
    checks++; if (err !== 1'b1 || outstanding !== 0) begin errors++; $display("FAIL err_set: got err=%0b cnt=%0d expected 1 0", err, outstanding); end
    step(); step(); #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %0b expected 1", err); end
    // reset mid-operation: a response for a pre-reset transfer must be flagged
    step(); m0_if.req = 1; mem_if.gnt = 1;
    do_reset(); #1;
    checks++; if (err !== 1'b0 || prio !== 1'b0 || outstanding !== 0) begin errors++; $display("FAIL err_reset: got err=%0b prio=%0b cnt=%0d expected 0 0 0", err, prio, outstanding); end
    step(); mem_if.r_valid = 1;
    step(); idle_all(); #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_stale_resp: got %0b expected 1", err); end
  endtask

  initial begin
    idle_all();
    test_reset();
    test_single_read();
    test_back_to_back();
    test_gnt_stall();
    test_full();
    test_simultaneous();
    test_error();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory request interface (req/gnt/r_valid) between two requesters: M0 (AXI slave memory wrap) and M1 (second master, e.g. DMA or debug port).
- Round-robin arbitration of requests.
- In-order response routing via an internal owner FIFO.
- Outstanding-transaction limiting.
- Sits between the requesters and the memory macro wrapper, one clock domain.

Parameters:
- ADDR_WIDTH, 32, memory address width
- DATA_WIDTH, 32, data width
- STRB_WIDTH, DATA_WIDTH/8, byte-enable width
- MAX_OUTSTANDING, 4, max granted-but-unanswered transactions (power of 2, >=2)
- CNT_WIDTH, $clog2(MAX_OUTSTANDING)+1, outstanding counter width

Ports:
- clk  in  1  clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- m0_req_i  in  1  M0 request
- m0_add_i  in  ADDR_WIDTH  M0 address
- m0_wen_i  in  1  M0 write enable (1 = write, 0 = read)
- m0_wdata_i  in  DATA_WIDTH  M0 write data
- m0_be_i  in  STRB_WIDTH  M0 byte enables
- m0_gnt_o  out  1  M0 request accepted this cycle
- m0_r_valid_o  out  1  M0 response valid
- m0_r_rdata_o  out  DATA_WIDTH  M0 read data
- m1_* (req_i, add_i, wen_i, wdata_i, be_i, gnt_o, r_valid_o, r_rdata_o)  same widths and meaning for M1
- data_req_o  out  1  memory request
- data_add_o  out  ADDR_WIDTH  memory address
- data_wen_o  out  1  memory write enable
- data_wdata_o  out  DATA_WIDTH  memory write data
- data_be_o  out  STRB_WIDTH  memory byte enables
- data_gnt_i  in  1  memory accepted request
- data_r_valid_i  in  1  memory response valid (one per granted request, reads and writes, in order, latency >=1)
- data_r_rdata_i  in  DATA_WIDTH  memory read data
- outstanding_o  out  CNT_WIDTH  current outstanding count
- err_o  out  1  sticky: response with no outstanding transaction

Behaviour:
- Clock and reset: single clock clk; reset synchronous active-high.
- Reset state:
  - prio pointer = M0
  - owner FIFO empty
  - outstanding_o = 0
  - err_o = 0
  - All combinational outputs evaluate to 0 while no request.
- Handshake: a transfer occurs when data_req_o & data_gnt_i in the same cycle. Requesters hold req and payload stable until their gnt; the arbiter must not depend on that.
- Blocking: full = (outstanding == MAX_OUTSTANDING). When full, data_req_o = 0 and no gnt is returned, even if data_r_valid_i pops this cycle. There is no combinational path from r_valid to req.
- Selection (combinational, same cycle):
  - Only one requester active: select it.
  - Both active: select the prio pointer.
  - data_req_o = (m0_req_i | m1_req_i) & ~full.
  - data_add/wen/wdata/be_o mux from the selected requester, else 0.
  - mX_gnt_o = data_gnt_i & data_req_o & (sel == X).
- Round-robin: on each transfer, prio <= the non-selected requester. No transfer: prio holds. A requester cannot be starved for more than one transfer while the other is continuously requesting.
- Owner FIFO (MAX_OUTSTANDING x 1 bit):
  - Push the selected ID on transfer; pop on data_r_valid_i.
  - Simultaneous push and pop allowed, count unchanged.
  - Pointers wrap modulo MAX_OUTSTANDING.
- Response routing (combinational):
  - mX_r_valid_o = data_r_valid_i & (head == X) & ~empty.
  - Both mX_r_rdata_o = data_r_rdata_i (unqualified).
- Error: data_r_valid_i while the FIFO is empty sets err_o (sticky until reset). No pop, no r_valid to either requester, count stays 0.
- Latency:
  - Grant is zero-cycle (combinational from data_gnt_i).
  - Response is zero-cycle pass-through.
  - Arbiter adds no pipeline stage.
- Counter:
  - outstanding <= outstanding + push - pop.
  - Never exceeds MAX_OUTSTANDING; never underflows (see Error).
- Reset mid-operation:
  - FIFO and count are cleared.
  - Responses arriving after reset for pre-reset transactions trigger err_o. Memory must be reset together with the arbiter.
- Requester drops req without gnt: allowed; the arbiter simply re-evaluates next cycle and prio is unchanged.

Test Plan:
- Single M0 read, addr 0x10, gnt same cycle, r_valid 2 cycles later, rdata 0xDEADBEEF -> m0_gnt_o=1 at cycle 0, m0_r_valid_o=1 with 0xDEADBEEF at cycle 2, m1_r_valid_o=0, outstanding 1 then 0.
- M0 and M1 both requesting continuously, gnt always 1, latency 2 -> grants alternate M0,M1,M0,M1; responses route in the same order; outstanding stays <=2.
- gnt held low for 3 cycles with both requesting -> no gnt outputs, prio unchanged, addr stays M0's; grant goes to M0 when gnt rises.
- MAX_OUTSTANDING=4, responses withheld -> 4 transfers, then data_req_o=0 with req high. One r_valid -> count 3, next cycle req reasserts.
- Simultaneous transfer and response at count 2 -> count stays 2; response goes to FIFO head, new ID is queued at tail.
- r_valid with FIFO empty -> err_o=1 and stays 1; no requester r_valid. Reset -> err_o=0, prio=M0, outstanding 0.
